// File: rtl/ps2_pkg.sv
// Definitions shared by the PS/2 device transmitter and the PS/2 receiver:
// controller states, frame length and the odd-parity rule.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } ps2_state_t;

  localparam int FRAME_BITS = 11;

  // Parity bit that gives data+parity an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_tick_gen.sv
// Half-period tick for the PS/2 clock: a down-counter that fires on terminal
// count and reloads; load restarts a fresh high phase when a frame begins.
module ps2_tick_gen #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(HALF_PERIOD);
  localparam logic [CW-1:0] LOAD_VAL = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en) begin
      if (cnt == '0) cnt <= LOAD_VAL;
      else           cnt <= cnt - CW'(1);
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard (device side) transmitter: sends one 11-bit frame per
// accepted byte, then holds both lines high for the inter-frame gap.
//
//   state | meaning
//   IDLE  | lines high, ready for a byte
//   SEND  | shifting start, 8 data, parity, stop; ps2_clk toggles per tick
//   GAP   | lines high, waiting out the inter-frame gap
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       busy,
  output logic       ps2_clk,
  output logic       ps2_dat
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  // The single IDLE cycle before the next acceptance is the last gap cycle.
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

  ps2_state_t              state;
  logic [3:0]              bit_cnt;
  logic [FRAME_BITS-2:0]   shreg;
  logic [GW-1:0]           gap_cnt;
  logic                    accept;
  logic                    half_tick;

  assign accept = valid && ready;

  ps2_tick_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .load(accept),
    .en  (state == SEND),
    .tick(half_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ps2_clk <= 1'b1;
      ps2_dat <= 1'b1;
      bit_cnt <= '0;
      shreg   <= '0;
      gap_cnt <= '0;
      ready   <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SEND;
            shreg   <= {1'b1, odd_parity(data), data};
            ps2_dat <= 1'b0;
            ps2_clk <= 1'b1;
            bit_cnt <= '0;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SEND: begin
          if (half_tick) begin
            if (ps2_clk) begin
              ps2_clk <= 1'b0;
            end else begin
              // End of a low phase: data only moves while ps2_clk is high.
              ps2_clk <= 1'b1;
              if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                ps2_dat <= 1'b1;
                if (GAP_CYCLES > 1) begin
                  state   <= GAP;
                  gap_cnt <= GAP_LOAD;
                end else begin
                  state <= IDLE;
                  ready <= 1'b1;
                  busy  <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                ps2_dat <= shreg[0];
                shreg   <= {1'b0, shreg[FRAME_BITS-2:1]};
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          ps2_clk <= 1'b1;
          ps2_dat <= 1'b1;
          ready   <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
